// File: rtl/uart_msg_tx_if.sv
// Request/serial-line bundle for the message transmitter.
interface uart_msg_tx_if #(
  parameter int MSG_LEN = 16,
  parameter int LW      = $clog2(MSG_LEN + 1)
);
  logic [MSG_LEN*8-1:0] message;
  logic [LW-1:0]        len;
  logic                 start;
  logic                 tx;
  logic                 busy;
  logic                 done;

  modport master (output message, len, start, input tx, busy, done);
  modport slave  (input message, len, start, output tx, busy, done);
endinterface

// File: rtl/uart_msg_tx.sv
// Captures a message on start and serialises it as back-to-back 8N1 frames,
// with optional null termination and CR/LF trailer.
module uart_msg_tx #(
  parameter int MSG_LEN      = 16,
  parameter int CLOCK_DIVIDE = 108,
  parameter int NULL_TERM    = 1,
  parameter int APPEND_CRLF  = 0,
  parameter int LW           = $clog2(MSG_LEN + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_msg_tx_if.slave bus
);
  localparam int IW = $clog2(MSG_LEN + 2);
  localparam int DW = $clog2(CLOCK_DIVIDE);

  // IDLE: wait for start | START/DATA/STOP: frame bits | FINISH: done pulse
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, FINISH} state_t;
  typedef enum logic [1:0] {SEL_BODY, SEL_CR, SEL_LF} sel_t;

  state_t               state, state_nxt;
  sel_t                 sel;
  logic [MSG_LEN*8-1:0] shadow;
  logic [LW-1:0]        eff_len;
  logic [IW-1:0]        idx;
  logic [7:0]           cur_byte;
  logic [2:0]           bit_cnt;
  logic [DW-1:0]        div;

  logic [LW-1:0] len_clamp;
  logic          first_empty;
  logic          div_zero;
  logic [IW-1:0] nidx;
  logic [7:0]    nbyte;
  logic          body_next;
  logic          more;

  always_comb begin
    len_clamp   = (bus.len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : bus.len;
    first_empty = (len_clamp == '0) || ((NULL_TERM != 0) && (bus.message[7:0] == 8'h00));
    div_zero    = (div == '0);
    nidx        = idx + IW'(1);
    nbyte       = 8'h00;
    for (int i = 0; i < MSG_LEN; i++)
      if (nidx == IW'(i)) nbyte = shadow[8*i +: 8];
    // nidx is compared against the clamped length, so it never indexes past the shadow
    body_next = (sel == SEL_BODY) && (nidx < IW'(eff_len)) &&
                ((NULL_TERM == 0) || (nbyte != 8'h00));
    more      = body_next || ((APPEND_CRLF != 0) && (sel != SEL_LF));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)
                 state_nxt = (first_empty && (APPEND_CRLF == 0)) ? FINISH : START;
      START:   if (div_zero) state_nxt = DATA;
      DATA:    if (div_zero && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:    if (div_zero) state_nxt = more ? START : FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.tx   = 1'b1;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      START:   begin bus.tx = 1'b0;              bus.busy = 1'b1; end
      DATA:    begin bus.tx = cur_byte[bit_cnt]; bus.busy = 1'b1; end
      STOP:    bus.busy = 1'b1;
      FINISH:  bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      eff_len  <= '0;
      idx      <= '0;
      sel      <= SEL_BODY;
      cur_byte <= 8'h00;
      bit_cnt  <= 3'd0;
      div      <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          shadow  <= bus.message;
          eff_len <= len_clamp;
          idx     <= '0;
          bit_cnt <= 3'd0;
          div     <= DW'(CLOCK_DIVIDE - 1);
          if (first_empty) begin
            sel      <= SEL_CR;
            cur_byte <= 8'h0D;
          end else begin
            sel      <= SEL_BODY;
            cur_byte <= bus.message[7:0];
          end
        end
        START, DATA: begin
          if (div_zero) begin
            div <= DW'(CLOCK_DIVIDE - 1);
            if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
          end else begin
            div <= div - DW'(1);
          end
        end
        STOP: begin
          if (div_zero) begin
            div <= DW'(CLOCK_DIVIDE - 1);
            if (body_next) begin
              idx      <= nidx;
              cur_byte <= nbyte;
            end else if (sel == SEL_BODY) begin
              sel      <= SEL_CR;
              cur_byte <= 8'h0D;
            end else if (sel == SEL_CR) begin
              sel      <= SEL_LF;
              cur_byte <= 8'h0A;
            end
          end else begin
            div <= div - DW'(1);
          end
        end
        FINISH: begin
          idx <= '0;
          div <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_msg_tx.sv
// Directed bench: two instances (plain and CR/LF trailer) observed by a UART receiver model.
module tb_uart_msg_tx;
  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] message = '0;
  logic [2:0]  len = '0;
  logic        start = 1'b0;

  uart_msg_tx_if #(.MSG_LEN(4)) bus0 ();
  uart_msg_tx_if #(.MSG_LEN(4)) bus1 ();

  assign bus0.message = message;
  assign bus0.len     = len;
  assign bus0.start   = start;
  assign bus1.message = message;
  assign bus1.len     = len;
  assign bus1.start   = start;

  uart_msg_tx #(.MSG_LEN(4), .CLOCK_DIVIDE(CD), .NULL_TERM(1), .APPEND_CRLF(0))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
  uart_msg_tx #(.MSG_LEN(4), .CLOCK_DIVIDE(CD), .NULL_TERM(1), .APPEND_CRLF(1))
    dut_crlf (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q[$];
  int         starts_q[$];
  int busy_cnt, done_cnt, done_cyc, rx_err;
  logic done_busy, first_tx, first_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse (or hold) start, then watch one DUT for ncyc cycles with a receiver model.
  task automatic run(input bit which, input logic [31:0] msg, input logic [2:0] ln,
                     input bit hold, input int poke_at, input logic [31:0] poke_msg,
                     input int ncyc);
    int rx_pos;
    logic [7:0] rx_sh;
    logic t, b_s, d_s;
    rx_q.delete();
    starts_q.delete();
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; rx_err = 0;
    done_busy = 1'b0; first_tx = 1'b1; first_busy = 1'b0;
    rx_pos = -1; rx_sh = '0;
    @(negedge clk);
    message = msg; len = ln; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      t   = which ? bus1.tx   : bus0.tx;
      b_s = which ? bus1.busy : bus0.busy;
      d_s = which ? bus1.done : bus0.done;
      if (c == 1) begin first_tx = t; first_busy = b_s; end
      if (b_s) busy_cnt++;
      if (d_s) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; done_busy = b_s; end
      end
      if (rx_pos < 0 && !t) begin rx_pos = 0; starts_q.push_back(c); end
      if (rx_pos >= 0) begin
        if (rx_pos % CD == CD/2) begin
          int b;
          b = rx_pos / CD;
          if (b == 0) begin if (t) rx_err++; end
          else if (b <= 8) rx_sh[b-1] = t;
          else begin if (!t) rx_err++; rx_q.push_back(rx_sh); end
        end
        if (rx_pos == 9*CD + CD/2) rx_pos = -1; else rx_pos++;
      end
      if (c == 1) start = hold;
      if (c == poke_at) begin message = poke_msg; start = 1'b1; end
      if (c == poke_at + 1) start = hold;
    end
  endtask

  function automatic logic [31:0] packed_rx();
    logic [31:0] g;
    g = '0;
    for (int i = 0; i < rx_q.size() && i < 4; i++) g[8*i +: 8] = rx_q[i];
    return g;
  endfunction

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    bit          which;
    logic [31:0] msg;
    logic [2:0]  ln;
    int          nfr;
    logic [31:0] bytes;
    int          busy;
    int          done_at;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{"abcd",       1'b0, 32'h44434241, 3'd4, 4, 32'h44434241, 160, 161};
    vt[1] = '{"null_stop",  1'b0, 32'h00004241, 3'd4, 2, 32'h00004241,  80,  81};
    vt[2] = '{"len1",       1'b0, 32'h00004241, 3'd1, 1, 32'h00000041,  40,  41};
    vt[3] = '{"len_clamp",  1'b0, 32'h44434241, 3'd7, 4, 32'h44434241, 160, 161};
    vt[4] = '{"empty",      1'b0, 32'h44434241, 3'd0, 0, 32'h00000000,   0,   1};
    vt[5] = '{"null_first", 1'b0, 32'h44434200, 3'd4, 0, 32'h00000000,   0,   1};
    vt[6] = '{"empty_crlf", 1'b1, 32'h44434241, 3'd0, 2, 32'h00000A0D,  80,  81};
    vt[7] = '{"body_crlf",  1'b1, 32'h00004241, 3'd4, 4, 32'h0A0D4241, 160, 161};

    repeat (3) @(negedge clk);
    chk("rst_tx",        bus0.tx,   1'b1);
    chk("rst_busy",      bus0.busy, 1'b0);
    chk("rst_done",      bus0.done, 1'b0);
    chk("rst_tx_crlf",   bus1.tx,   1'b1);
    chk("rst_busy_crlf", bus1.busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vt[k]) begin
      int gap_err;
      run(vt[k].which, vt[k].msg, vt[k].ln, 1'b0, -1, 32'h0, 200);
      chk({vt[k].name, "_nframes"}, rx_q.size(), vt[k].nfr);
      chk({vt[k].name, "_bytes"},   packed_rx(), vt[k].bytes);
      chk({vt[k].name, "_busy"},    busy_cnt,    vt[k].busy);
      chk({vt[k].name, "_done_at"}, done_cyc,    vt[k].done_at);
      chk({vt[k].name, "_done_cnt"}, done_cnt,   1);
      chk({vt[k].name, "_done_busy"}, done_busy, 1'b0);
      chk({vt[k].name, "_rx_err"},  rx_err,      0);
      chk({vt[k].name, "_first_tx"},   first_tx,   (vt[k].nfr == 0));
      chk({vt[k].name, "_first_busy"}, first_busy, (vt[k].nfr != 0));
      gap_err = 0;
      for (int i = 1; i < starts_q.size(); i++)
        if (starts_q[i] - starts_q[i-1] != 10*CD) gap_err++;
      chk({vt[k].name, "_frame_gap"}, gap_err, 0);
    end

    // Extra start and message change mid-transfer are ignored.
    run(1'b0, 32'h44434241, 3'd4, 1'b0, 60, 32'h55555555, 220);
    chk("interlock_bytes",    packed_rx(), 32'h44434241);
    chk("interlock_nframes",  rx_q.size(), 4);
    chk("interlock_busy",     busy_cnt,    160);
    chk("interlock_done_cnt", done_cnt,    1);

    // start held high: one idle cycle after done, then the next start bit.
    run(1'b0, 32'h00000041, 3'd1, 1'b1, -1, 32'h0, 100);
    chk("hold_done_at", done_cyc, 41);
    chk("hold_second_start", (starts_q.size() > 1) ? starts_q[1] : -1, 43);
    pulse_reset();

    // Reset during data bit 0 of byte 1 (0x42, bit0 = 0).
    @(negedge clk);
    message = 32'h44434241; len = 3'd4; start = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    chk("pre_reset_tx",   bus0.tx,   1'b0);
    chk("pre_reset_busy", bus0.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx",   bus0.tx,   1'b1);
    chk("async_rst_busy", bus0.busy, 1'b0);
    chk("async_rst_done", bus0.done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle_tx", bus0.tx, 1'b1);
    run(1'b0, 32'h44434241, 3'd1, 1'b0, -1, 32'h0, 60);
    chk("post_rst_bytes", packed_rx(), 32'h00000041);
    chk("post_rst_nframes", rx_q.size(), 1);
    chk("post_rst_busy",  busy_cnt, 40);
    chk("post_rst_start", (starts_q.size() > 0) ? starts_q[0] : -1, 1);
    chk("post_rst_rx_err", rx_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_msg_tx.md
# uart_msg_tx

Parametrised message-to-UART transmitter. It captures a multi-byte message on a start request and serialises it as back-to-back 8N1 frames on a single TX line. It has an integrated bit timer, so no separate uart instance is needed. It supports an explicit length, optional null termination and optional CR/LF append. It sits between status/debug logic and the board's serial pin, and is fully synchronous to one clock.

## Interface
- MSG_LEN, 16, maximum message bytes (1..255)
- CLOCK_DIVIDE, 108, clk cycles per serial bit (>=2)
- NULL_TERM, 1, 1: stop at first 0x00 byte; 0: send exactly len bytes
- APPEND_CRLF, 0, 1: send 0x0D then 0x0A after the message body
- LW, $clog2(MSG_LEN+1), width of len
- clk  in  1  master clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- message  in  MSG_LEN*8  byte i at message[8*i+7:8*i]; byte 0 is sent first
- len  in  LW  number of body bytes requested
- start  in  1  request; sampled high in IDLE starts a transfer
- tx  out  1  serial line, idle high
- busy  out  1  high from the first start-bit cycle through the last stop-bit cycle
- done  out  1  one-cycle pulse when a transfer (or empty request) finishes

## Operation
- Reset values: tx=1, busy=0, done=0, state=IDLE, byte index=0, bit counter=0, divider=0.
- States:
  - IDLE: on start=1, latch message into a shadow register and latch eff_len=min(len,MSG_LEN).
    - If eff_len==0, or NULL_TERM==1 and byte 0 is 0x00, with APPEND_CRLF==0: go to FINISH.
    - Otherwise go to START.
  - START: tx=0 for CLOCK_DIVIDE cycles, then DATA.
  - DATA: 8 bits, LSB first, CLOCK_DIVIDE cycles each, then STOP.
  - STOP: tx=1 for CLOCK_DIVIDE cycles. Then select the next byte:
    - next body byte if index+1<eff_len and that byte is non-null (NULL_TERM==1);
    - otherwise CR, then LF, if APPEND_CRLF;
    - otherwise FINISH.
    - When a next byte exists, go to START with no idle gap.
  - FINISH: done=1 for exactly one cycle, busy=0, return to IDLE.
- Empty request with APPEND_CRLF==1 sends CR, LF only.
- The shadow register isolates the transfer from later changes on message or len.
- start is ignored while not in IDLE. No queuing: a request during busy is lost.
- The null byte itself is never transmitted.
- Index width is $clog2(MSG_LEN+2). Comparisons use eff_len and never wrap.

## Timing
- Latency: start sampled at edge N gives tx=0 and busy=1 from edge N+1.
- Each frame lasts exactly 10*CLOCK_DIVIDE cycles.
- A k-byte transfer holds busy for 10*k*CLOCK_DIVIDE cycles.
- done is asserted in the cycle after the last stop-bit cycle. busy is 0 in that cycle.
- Empty request: done pulses at edge N+1, busy stays 0, tx stays 1.
- start held high continuously: a new transfer begins the cycle after done. IDLE lasts 1 cycle.
- Reset mid-frame: tx returns high immediately (asynchronous). busy and done clear. No partial byte resumes after reset release.
- Bit boundaries come from the divider counter, reloaded at every bit start. There is no cumulative drift.

## Test plan
- Test configuration for all scenarios: MSG_LEN=4, CLOCK_DIVIDE=4, NULL_TERM=1, APPEND_CRLF=0.
- Basic send: message="ABCD" (0x44434241), len=4, start pulse.
  - Expect frames 0x41, 0x42, 0x43, 0x44, each 40 cycles, busy high 160 cycles.
  - Expect one done pulse, decoded by the bench's UART receiver model.
- Null and length: message 0x00004241, len=4 -> exactly 2 frames (0x41, 0x42), done after 80 busy cycles.
  - Same message with len=1 -> 1 frame.
  - len=7 -> clamped to 4.
- Empty request: len=0 -> done one cycle after start, busy never high, tx constant 1.
  - Same with APPEND_CRLF=1 -> frames 0x0D, 0x0A only.
- Busy interlock: start pulses and message changes mid-transfer.
  - Output matches the originally latched bytes; the extra starts are ignored.
  - start held high -> second transfer's start bit is exactly 1 cycle after done.
- Reset mid-frame: assert rst_n=0 during the DATA bits of byte 1 -> tx=1, busy=0 asynchronously.
  - After release, a new start sends a clean frame 0x41 with correct 4-cycle bit widths.
